// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared memory-path widths, store buffer depth and word-align constants
package arm_mem_pkg;
    localparam int ARM_AW = 32;
    localparam int ARM_DW = 32;
    localparam int SB_DEPTH = 4;
    localparam int ALIGN_BITS = 2;
    localparam logic [ARM_AW-1:0] WORD_MASK = ~ARM_AW'(3);
endpackage

// File: rtl/sb_match.sv
// sb_match: forwarding lookup, returns data of the youngest valid entry whose address equals la
// ports: en (lookup enable), la (word-aligned lookup address), head/count (ring state),
//        adr/dat (storage array), hit/data (forwarding result, zero when no hit)
module sb_match
    import arm_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW = ARM_AW,
    parameter int DW = ARM_DW
) (
    input  logic                           en,
    input  logic [AW-1:0]                  la,
    input  logic [$clog2(DEPTH)-1:0]       head,
    input  logic [$clog2(DEPTH):0]         count,
    input  logic [DEPTH-1:0][AW-1:0]       adr,
    input  logic [DEPTH-1:0][DW-1:0]       dat,
    output logic                           hit,
    output logic [DW-1:0]                  data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0] idx;
    // walk oldest to youngest so the last match wins
    always_comb begin
        hit = 1'b0;
        data = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (en && CW'(k) < count && adr[idx] == la) begin
                hit = 1'b1;
                data = dat[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of CPU stores draining to data memory, with load forwarding
// ports: clk, Reset (sync active-low), MemWrite/MemRead/DataAdr/WriteData (CPU side),
//        Stall (store refused), FwdHit/FwdData (forwarding), MemReq/MemAdr/MemWData/MemAck
//        (memory side, head entry), Count (valid entries)
module store_buffer
    import arm_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW = ARM_AW,
    parameter int DW = ARM_DW
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    input  logic [AW-1:0]            DataAdr,
    input  logic [DW-1:0]            WriteData,
    output logic                     Stall,
    output logic                     FwdHit,
    output logic [DW-1:0]            FwdData,
    output logic                     MemReq,
    output logic [AW-1:0]            MemAdr,
    output logic [DW-1:0]            MemWData,
    input  logic                     MemAck,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DEPTH-1:0][AW-1:0] adr_q;
    logic [DEPTH-1:0][DW-1:0] dat_q;
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic full, push, pop;
    // full comes from the registered count, so a same-cycle ack never admits a store
    assign full = cnt == CW'(DEPTH);
    assign push = MemWrite & ~full;
    assign pop = MemReq & MemAck;
    assign Stall = MemWrite & full;
    assign MemReq = cnt != '0;
    assign MemAdr = adr_q[head];
    assign MemWData = dat_q[head];
    assign Count = cnt;
    always_ff @(posedge clk) begin
        if (Reset && push) begin
            adr_q[tail] <= DataAdr;
            dat_q[tail] <= WriteData;
        end
    end
    always_ff @(posedge clk) begin
        if (!Reset) begin
            head <= '0;
            tail <= '0;
            cnt <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    sb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match (
        .en(MemRead),
        .la({DataAdr[AW-1:ALIGN_BITS], ALIGN_BITS'(0)}),
        .head(head),
        .count(cnt),
        .adr(adr_q),
        .dat(dat_q),
        .hit(FwdHit),
        .data(FwdData)
    );
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a queue model checked every cycle plus literal checks
module tb_store_buffer;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic Reset = 1'b0;
    logic MemWrite = 1'b0, MemRead = 1'b0, MemAck = 1'b0;
    logic [31:0] DataAdr = '0, WriteData = '0;
    logic Stall, FwdHit, MemReq;
    logic [31:0] FwdData, MemAdr, MemWData;
    logic [2:0] Count;
    int compared = 0, mismatched = 0;
    logic armed = 1'b0;
    logic [31:0] qa[$], qd[$];
    logic [31:0] da[$], dd[$];

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .Reset(Reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .DataAdr(DataAdr), .WriteData(WriteData), .Stall(Stall), .FwdHit(FwdHit),
        .FwdData(FwdData), .MemReq(MemReq), .MemAdr(MemAdr), .MemWData(MemWData),
        .MemAck(MemAck), .Count(Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        int n = 0;
        MemAck = 1'b1;
        MemWrite = 1'b0;
        MemRead = 1'b0;
        while (Count != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(Count), 0);
        MemAck = 1'b0;
    endtask

    // model: queue of accepted stores, oldest at index 0
    always @(posedge clk) begin
        if (!Reset) begin
            qa.delete();
            qd.delete();
        end else begin
            automatic bit full = qa.size() == DEPTH;
            if (qa.size() != 0 && MemAck) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (MemWrite && !full) begin
                qa.push_back(DataAdr);
                qd.push_back(WriteData);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            automatic logic eh = 1'b0;
            automatic logic [31:0] ed = '0;
            if (MemRead)
                for (int i = qa.size() - 1; i >= 0; i--)
                    if (!eh && qa[i] == (DataAdr & 32'hFFFF_FFFC)) begin
                        eh = 1'b1;
                        ed = qd[i];
                    end
            chk("m_count", 32'(Count), qa.size());
            chk("m_memreq", 32'(MemReq), 32'(qa.size() != 0));
            chk("m_stall", 32'(Stall), 32'(MemWrite && qa.size() == DEPTH));
            chk("m_fwdhit", 32'(FwdHit), 32'(eh));
            chk("m_fwddata", FwdData, ed);
            if (qa.size() != 0) begin
                chk("m_memadr", MemAdr, qa[0]);
                chk("m_memwdata", MemWData, qd[0]);
            end
            if (MemReq && MemAck && Reset) begin
                da.push_back(MemAdr);
                dd.push_back(MemWData);
            end
        end
    end

    initial begin
        automatic logic ph = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        armed = 1'b1;
        MemRead = 1'b1;
        settle();
        chk("rst_count", 32'(Count), 0);
        chk("rst_memreq", 32'(MemReq), 0);
        chk("rst_fwdhit", 32'(FwdHit), 0);
        chk("rst_fwddata", FwdData, 0);
        MemRead = 1'b0;
        MemWrite = 1'b1; DataAdr = 100; WriteData = 7; MemAck = 1'b1;
        settle();
        chk("rst_stall", 32'(Stall), 0);
        tick();
        MemWrite = 1'b0;
        settle();
        chk("single_req", 32'(MemReq), 1);
        chk("single_adr", MemAdr, 100);
        chk("single_data", MemWData, 7);
        tick();
        chk("single_count", 32'(Count), 0);
        MemAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MemWrite = 1'b1; DataAdr = 32'(96 + 4 * i); WriteData = 32'(i + 1);
            tick();
        end
        DataAdr = 112; WriteData = 5;
        settle();
        chk("full_count", 32'(Count), 4);
        chk("full_stall", 32'(Stall), 1);
        tick();
        chk("full_hold", 32'(Count), 4);
        MemAck = 1'b1;
        settle();
        chk("full_ack_stall", 32'(Stall), 1);
        tick();
        MemAck = 1'b0;
        settle();
        chk("after_ack_count", 32'(Count), 3);
        chk("after_ack_stall", 32'(Stall), 0);
        chk("after_ack_head", MemAdr, 100);
        tick();
        MemWrite = 1'b0;
        settle();
        chk("late_accept", 32'(Count), 4);
        drain();
        MemWrite = 1'b1; DataAdr = 96; WriteData = 3;
        tick();
        WriteData = 5;
        tick();
        MemWrite = 1'b0; MemRead = 1'b1; DataAdr = 98;
        settle();
        chk("fwd_hit", 32'(FwdHit), 1);
        chk("fwd_young", FwdData, 5);
        DataAdr = 200;
        settle();
        chk("fwd_miss", 32'(FwdHit), 0);
        chk("fwd_miss_data", FwdData, 0);
        MemRead = 1'b0;
        MemWrite = 1'b1; DataAdr = 120; WriteData = 8; MemAck = 1'b1;
        tick();
        MemWrite = 1'b0; MemRead = 1'b1; DataAdr = 96;
        settle();
        chk("pp_count", 32'(Count), 2);
        chk("pp_head", MemWData, 5);
        chk("pop_fwd_hit", 32'(FwdHit), 1);
        chk("pop_fwd_data", FwdData, 5);
        tick();
        chk("pp_next_head", MemAdr, 120);
        drain();
        da.delete();
        dd.delete();
        for (int i = 0; i < 10; i++) begin
            automatic bit acc = 1'b0;
            automatic int g = 0;
            MemWrite = 1'b1; DataAdr = 32'(200 + 4 * i); WriteData = 32'(11 * i + 1);
            do begin
                MemAck = ph;
                ph = ~ph;
                settle();
                acc = !Stall;
                tick();
                g++;
            end while (!acc && g < 50);
        end
        drain();
        chk("wrap_len", da.size(), 10);
        for (int i = 0; i < 10 && i < da.size(); i++) begin
            chk("wrap_adr", da[i], 32'(200 + 4 * i));
            chk("wrap_data", dd[i], 32'(11 * i + 1));
        end
        for (int i = 0; i < 3; i++) begin
            MemWrite = 1'b1; DataAdr = 32'(400 + 4 * i); WriteData = 32'(i + 1);
            tick();
        end
        MemWrite = 1'b0;
        settle();
        chk("pre_rst_count", 32'(Count), 3);
        Reset = 1'b0; MemWrite = 1'b1; DataAdr = 412; MemAck = 1'b1; MemRead = 1'b1;
        tick();
        Reset = 1'b1; MemWrite = 1'b0; MemAck = 1'b0; MemRead = 1'b0;
        settle();
        chk("mid_rst_count", 32'(Count), 0);
        chk("mid_rst_req", 32'(MemReq), 0);
        MemRead = 1'b1; DataAdr = 404;
        settle();
        chk("mid_rst_fwd", 32'(FwdHit), 0);
        tick();
        MemRead = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 Reset  input  1  synchronous, active-low reset (Reset=0 at posedge resets).
REQ-006 MemWrite  input  1  CPU store request this cycle.
REQ-007 MemRead  input  1  CPU load request this cycle (forwarding lookup).
REQ-008 DataAdr  input  AW  CPU store/load address.
REQ-009 WriteData  input  DW  CPU store data.
REQ-010 Stall  output  1  store refused this cycle; CPU holds PC and store.
REQ-011 FwdHit  output  1  load address matches a buffered store.
REQ-012 FwdData  output  DW  data of youngest matching buffered store.
REQ-013 MemReq  output  1  head entry valid, offered to data memory.
REQ-014 MemAdr  output  AW  head entry address.
REQ-015 MemWData  output  DW  head entry data.
REQ-016 MemAck  input  1  data memory accepts head entry this cycle.
REQ-017 Count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 SHALL be a circular FIFO of {address, data}, head/tail pointers wrapping modulo DEPTH.
REQ-019 SHALL push at posedge when MemWrite=1 and Count<DEPTH; address and data stored verbatim (DataAdr[1:0] not altered).
REQ-020 SHALL drive Stall = MemWrite & (Count==DEPTH), combinationally; a refused store is not written.
REQ-021 Full status SHALL use registered Count only: a MemAck in the same cycle as a store at Count==DEPTH does not admit the store.
REQ-022 SHALL drive MemReq = (Count!=0); MemAdr/MemWData SHALL show the head entry, stable until acked.
REQ-023 SHALL pop at posedge when MemReq=1 and MemAck=1; MemAck while MemReq=0 SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave Count unchanged; pop-only decrements, push-only increments.
REQ-025 Drain order SHALL equal acceptance order, including across pointer wrap.
REQ-026 Stores to an address already buffered SHALL create a new entry (no coalescing).
REQ-027 When MemRead=1, FwdHit SHALL be 1 iff any valid entry address equals DataAdr[AW-1:2]&lt;&lt;2 (word compare), combinationally in the same cycle.
REQ-028 FwdData SHALL be the youngest matching entry; entry being popped this cycle still counts as valid.
REQ-029 When MemRead=0 or no match, FwdHit=0 and FwdData=0.
REQ-030 Store accepted in cycle N SHALL be visible on MemReq/forwarding from cycle N+1 (latency 1).

Reset
REQ-031 Reset=0 at posedge SHALL set head=tail=0, Count=0; hence MemReq=0, Stall=0, FwdHit=0, FwdData=0.
REQ-032 Reset mid-operation SHALL discard all pending stores; storage array contents need not be cleared.
REQ-033 MemWrite, MemRead, MemAck SHALL be ignored while Reset=0.

Structure
REQ-034 Shared package arm_mem_pkg SHALL hold AW, DW, default DEPTH and word-align mask constants.
REQ-035 Forwarding comparator plus youngest-match priority select SHALL be sub-module sb_match.
REQ-036 Storage array SHALL have no reset; only pointers/Count are reset.

Verification
REQ-037 Store 100&lt;-7, MemAck=1 held -> next cycle MemReq=1, MemAdr=100, MemWData=7; following cycle Count=0.
REQ-038 MemAck=0, stores to 96,100,104,108 -> Count=4; 5th store to 112 -> Stall=1, Count stays 4; one ack -> 112 accepted next cycle.
REQ-039 Stores 96&lt;-3 then 96&lt;-5, then MemRead at 98 -> FwdHit=1, FwdData=5; MemRead at 200 -> FwdHit=0.
REQ-040 Count=2, store and MemAck same cycle -> Count stays 2, head advances, new entry at tail.
REQ-041 10 stores with alternating MemAck (pointer wrap) -> drained sequence of addresses/data matches issue order exactly.
REQ-042 Count=3, Reset=0 for one cycle -> Count=0, MemReq=0; later MemRead at a previously stored address -> FwdHit=0.
